// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit beside the EX-stage ALU.
// An M-extension op (selected by Funct3) runs a radix-2 shift-add multiply or a
// restoring divide for XLEN cycles. One FIX cycle then sign-corrects and
// registers the result. A DONE cycle follows, in which result_valid pulses.
// Divide-by-zero and signed overflow skip the loop and go straight to FIX.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   op request, sampled only in IDLE
//   Funct3       in   3'b000 MUL .. 3'b111 REMU
//   SrcA, SrcB   in   rs1 / rs2 operands
//   flush        in   abort the current op; also blocks a same-cycle start in IDLE
//   busy         out  registered, high while the FSM is not IDLE
//   result_valid out  registered one-cycle pulse in DONE
//   Result       out  last result, held until the next result_valid
//   o_dbg_state  out  current FSM state (state_t encoding)
//
// Handshake: start is a level request and is taken only on an edge where the FSM
// is IDLE and flush is low. There is no back-pressure on the result. The
// consumer must capture Result on the cycle when result_valid is high.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] Result,
  output logic [2:0]      o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_opa;      // multiplicand magnitude
  logic [XLEN-1:0]     r_opb;      // divisor magnitude
  logic [XLEN-1:0]     r_a_raw;    // unmodified SrcA, the remainder on divide-by-zero
  logic [2*XLEN-1:0]   r_prod;     // product, or remainder(hi):quotient(lo)
  logic                r_neg_a, r_neg_b, r_dz, r_ovf;
  logic                r_busy, r_valid;
  logic [XLEN-1:0]     r_result;

  // Operand decode. A is signed for MUL/MULH/MULHSU/DIV/REM.
  // B is signed for the same ops except MULHSU.
  logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_dz, w_ovf;
  logic [XLEN-1:0] w_a_mag, w_b_mag;

  assign w_a_signed = ~(Funct3[0] & (Funct3[1] | Funct3[2]));
  assign w_b_signed = w_a_signed & (Funct3 != 3'b010);
  assign w_a_neg    = w_a_signed & SrcA[XLEN-1];
  assign w_b_neg    = w_b_signed & SrcB[XLEN-1];
  assign w_a_mag    = w_a_neg ? -SrcA : SrcA;
  assign w_b_mag    = w_b_neg ? -SrcB : SrcB;
  assign w_dz       = Funct3[2] & (SrcB == '0);
  assign w_ovf      = Funct3[2] & ~Funct3[0] & (SrcA == MIN_INT) & (SrcB == '1);

  // Iteration datapath
  logic [XLEN:0] w_mul_sum, w_div_sh, w_div_diff;
  assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, r_opa};
  assign w_div_sh   = r_prod[2*XLEN-2:XLEN-1];  // remainder after the left shift
  assign w_div_diff = w_div_sh - {1'b0, r_opb};

  // Result selection and sign correction in FIX
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix;
  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -r_prod : r_prod;
  assign w_quo      = (r_neg_a ^ r_neg_b) ? -r_prod[XLEN-1:0] : r_prod[XLEN-1:0];
  assign w_rem      = r_neg_a ? -r_prod[2*XLEN-1:XLEN] : r_prod[2*XLEN-1:XLEN];

  always_comb begin
    w_fix = '0;
    if (r_dz) begin
      w_fix = r_op[1] ? r_a_raw : '1;
    end else if (r_ovf) begin
      w_fix = r_op[1] ? '0 : MIN_INT;
    end else begin
      case (r_op)
        3'b000:                 w_fix = w_prod_fix[XLEN-1:0];
        3'b001, 3'b010, 3'b011: w_fix = w_prod_fix[2*XLEN-1:XLEN];
        3'b100, 3'b101:         w_fix = w_quo;
        default:                w_fix = w_rem;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!Funct3[2])        w_next = S_MUL;
          else if (w_dz || w_ovf) w_next = S_FIX;
          else                    w_next = S_DIV;
        end
      end
      S_MUL, S_DIV: if (r_cnt == LAST_CNT) w_next = S_FIX;
      S_FIX:        w_next = S_DONE;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
    // flush aborts any op and, in IDLE, also wins over start
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_a_raw  <= '0;
      r_prod   <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_valid <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_next != S_IDLE) begin
            r_cnt   <= '0;
            r_op    <= Funct3;
            r_opa   <= w_a_mag;
            r_opb   <= w_b_mag;
            r_a_raw <= SrcA;
            r_neg_a <= w_a_neg;
            r_neg_b <= w_b_neg;
            r_dz    <= w_dz;
            r_ovf   <= w_ovf;
            // Multiply shifts the multiplier out of the low half.
            // Divide shifts the dividend out of the low half while quotient bits enter.
            r_prod  <= {{XLEN{1'b0}}, (Funct3[2] ? w_a_mag : w_b_mag)};
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_prod[0]) r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
          else           r_prod <= {1'b0, r_prod[2*XLEN-1:1]};
        end
        S_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (!w_div_diff[XLEN])
            r_prod <= {w_div_diff[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};
          else
            r_prod <= {w_div_sh[XLEN-1:0], r_prod[XLEN-2:0], 1'b0};
        end
        S_FIX: begin
          if (w_next == S_DONE) r_result <= w_fix;
        end
        default: ;
      endcase
    end
  end

  assign busy         = r_busy;
  assign result_valid = r_valid;
  assign Result       = r_result;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit sitting beside the EX-stage ALU.
- Accepts an M-extension op, decoded from Funct3 when Funct7 = 7'b0000001, runs a radix-2 shift-add / restoring-divide loop for XLEN cycles, then returns a single-cycle result pulse.
- Holds the pipeline through `busy` for the duration of the loop.
- Divide-by-zero and signed overflow take a one-cycle fast path.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- Funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  XLEN  rs1 operand.
- SrcB  input  XLEN  rs2 operand.
- flush  input  1  abort the current op (branch mispredict/trap).
- busy  output  1  high while state != IDLE; pipeline stall request.
- result_valid  output  1  one-cycle pulse when result is valid.
- Result  output  XLEN  result; holds last value until the next result_valid.

Behaviour:
- Reset (reset = 0, async):
  - state = IDLE; counter = 0; busy = 0; result_valid = 0; Result = 0.
  - All internal registers cleared.
  - Takes effect mid-operation too; no result_valid is produced afterwards.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - start = 1 latches Funct3, SrcA, SrcB.
  - Signed ops (MUL/MULH/DIV/REM, and SrcA for MULHSU) convert operands to magnitude and record the result sign.
  - Next state:
    - Funct3[2] = 0 → MUL.
    - Funct3[2] = 1 and SrcB == 0 → FIX.
    - DIV/REM with SrcA == 0x80000000 and SrcB == 0xFFFFFFFF → FIX.
    - Otherwise → DIV.
- MUL:
  - Each cycle: if multiplier LSB = 1, add multiplicand into the upper half of a 2*XLEN product register, then shift right by 1.
  - counter increments each cycle; at counter == XLEN-1 → FIX.
- DIV:
  - Each cycle: shift remainder:quotient left by 1; trial subtract divisor from remainder.
  - If non-negative, keep the difference and set the quotient LSB.
  - At counter == XLEN-1 → FIX.
- FIX (one cycle): select and sign-correct the result, register it into Result, go to DONE.
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the product; negate the 2*XLEN product first if the sign flag is set.
  - DIV/DIVU: quotient, negated if sign(A) xor sign(B) for DIV.
  - REM/REMU: remainder, carrying the sign of A for REM.
  - Divide by zero: quotient = all ones; remainder = SrcA.
  - Overflow: DIV = 0x80000000; REM = 0.
- DONE: result_valid = 1 for exactly one cycle; busy still 1; next state IDLE.
- Latency from the start-sampling edge to the result_valid cycle:
  - Loop ops: XLEN + 2 edges (34 at XLEN = 32).
  - Fast path: 2 edges.
- busy is registered. The pipeline also stalls combinationally on (start && state == IDLE), which is the hazard unit's responsibility.
- start while busy = 1 is ignored; no queuing.
- flush:
  - In any non-IDLE state, flush → IDLE next edge; result_valid stays 0; Result unchanged.
  - flush in IDLE overrides a same-cycle start (op not accepted).
- Counter wrap is impossible: the counter is cleared on entry to MUL/DIV.
- One cycle after DONE the block is in IDLE and can accept start; back-to-back ops are separated by that cycle.

Test Plan:
- MUL 7 × -3 (SrcA = 7, SrcB = 0xFFFFFFFD) → result_valid 34 cycles after start; Result = 0xFFFFFFEB.
- MULH 0x80000000 × 0x80000000 → Result = 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → Result = 0xFFFFFFFE.
- DIV -20 / 6 → 0xFFFFFFFD. REM -20 / 6 → 0xFFFFFFFE. DIVU 100 / 7 → 14. REMU 100 / 7 → 2. All arrive after 34 cycles.
- Fast path (each result_valid 2 cycles after start, busy high for exactly 2 cycles):
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / -1 → 0x80000000.
  - REM 0x80000000 / -1 → 0.
- Abort and reset:
  - flush on cycle 10 of a DIV → busy drops next cycle; no result_valid; Result keeps its prior value.
  - reset low mid-MUL → busy = 0 and Result = 0 immediately.
- start pulsed on cycle 5 of a running MUL → ignored; only one result_valid. A new start on the cycle after DONE is accepted.
